shift_rx_deframer: RTL and testbench
====================================

# shift_rx_deframer

Downstream receive stage for the 8-bit load/shift-left output register. Watches the register's MSB (serial stream, MSB first) together with the same load strobe that drives the register. Reassembles each loaded byte, queues it in a small first-word-fall-through FIFO for a ready/valid consumer, and keeps a running XOR checksum plus error counters. Lives in the same tile top, fed directly from the shift register's bit 7 and its load control.

## Interface

Parameters:
- FIFO_DEPTH, 4, number of byte entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- load_in  in  1  same strobe that loads the shift register (sampled at the same edge).
- ser_in  in  1  shift register bit 7.
- rd_ready  in  1  consumer accepts head byte when high with rd_valid.
- clear  in  1  synchronous clear of overflow, abort_cnt, sum_xor; FIFO untouched.
- rd_data  out  8  FIFO head byte; 0 when empty.
- rd_valid  out  1  FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
- busy  out  1  frame capture in progress (state SHIFT).
- overflow  out  1  sticky: a completed byte was dropped because FIFO was full.
- abort_cnt  out  4  saturating count of frames aborted by a mid-frame reload.
- sum_xor  out  8  XOR of every byte written into the FIFO since reset/clear.

## Operation

- States: IDLE, SHIFT. 3-bit bit_cnt, 8-bit capture register sr.
- IDLE: load_in=1 → SHIFT, bit_cnt=0. Otherwise stay; ser_in ignored.
- SHIFT, each edge: sr ← {sr[6:0], ser_in}.
  - bit_cnt<7, load_in=0: bit_cnt+1.
  - bit_cnt<7, load_in=1: abort. Discard partial byte, abort_cnt+1 (saturate at 15), stay SHIFT, bit_cnt=0.
  - bit_cnt==7: byte complete = {sr[6:0], ser_in}. Push request. Next state SHIFT with bit_cnt=0 if load_in=1 (back-to-back), else IDLE.
- Push accepted when fifo_count<FIFO_DEPTH, or when full and a pop occurs at the same edge. Accepted: write byte at tail, sum_xor ← sum_xor ^ byte. Rejected: byte dropped, overflow ← 1, sum_xor unchanged.
- Pop: rd_valid & rd_ready at an edge; head advances.
- fifo_count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Pointers wrap modulo FIFO_DEPTH.
- clear=1 at an edge:
  - overflow, abort_cnt, sum_xor are zeroed.
  - A same-edge event then applies on top of the zeroed value: sum_xor=byte, abort_cnt=1, overflow=1.
- Reset (rst_n=0 at an edge):
  - state=IDLE, bit_cnt=0, sr=0, pointers=0.
  - fifo_count=0, rd_valid=0, rd_data=0, busy=0, overflow=0, abort_cnt=0, sum_xor=0.
  - Reset overrides every other input, including mid-frame. Partial byte is lost, no abort counted.

## Timing

- Load sampled at edge T0. Shift register holds byte B after T0, so ser_in = B[7-i] during cycle T0+i.
- Receiver samples ser_in at edges T1..T8. B enters the FIFO at T8.
- If the FIFO was empty before T8, rd_valid=1 and rd_data=B right after T8: 8-cycle load-to-valid latency.
- busy is high from after T0 until after T8 (low after T8 unless reloaded at T8).
- Reload exactly at T8 is legal back-to-back streaming, not an abort. Max throughput is one byte per 8 cycles.
- rd_data and rd_valid come combinationally from FIFO state, with no added latency. A pop at edge E exposes the next entry right after E.
- All outputs are registered or derived only from registers. No combinational path from inputs to outputs.

## Test plan

- Reset/idle: hold rst_n=0 two cycles, then release with load_in=0 for 20 cycles → all outputs 0, busy=0.
- Single byte: load 0xA5 at T0, rd_ready=0 → at T8 rd_valid=1, rd_data=0xA5, fifo_count=1, sum_xor=0xA5. Pop → rd_valid=0, rd_data=0.
- Back-to-back fill/overflow: load 0x11, 0x22, 0x33, 0x44, 0x55 every 8 cycles with rd_ready=0.
  - FIFO holds 11, 22, 33, 44; fifo_count=4.
  - 0x55 dropped, overflow=1, sum_xor=0x44.
  - Drain → 11, 22, 33, 44 in order.
- Full with simultaneous pop: FIFO full, rd_ready=1 at the T8 of byte 0x66 → count stays 4, overflow unchanged, 0x66 at tail.
- Abort: load 0xF0 at T0, reload 0x0F at T3 → abort_cnt=1. Only 0x0F is delivered, at T3+8. Repeat 20 aborts → abort_cnt saturates at 15.
- Clear and reset mid-frame:
  - clear at the T8 of byte 0x3C → sum_xor=0x3C, overflow=0, FIFO contents retained.
  - rst_n=0 at T4 of a frame → everything returns to 0, and no byte appears afterwards.

Source files
------------

// File: rtl/shift_rx_deframer.sv
// Receive side of the 8-bit load/shift-left register: rebuilds each loaded byte from bit 7,
// queues it in a first-word-fall-through FIFO and keeps an XOR checksum plus error counters.
module shift_rx_deframer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load_in,
   input  logic                          ser_in,
   input  logic                          rd_ready,
   input  logic                          clear,
   output logic [7:0]                    rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy,
   output logic                          overflow,
   output logic [3:0]                    abort_cnt,
   output logic [7:0]                    sum_xor
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    sr_q, sr_d;
   logic [7:0]    push_byte;
   logic          push_req;
   logic          abort_evt;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          full, pop, push_ok;
   logic [7:0]    sum_base;
   logic [3:0]    abort_base;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= 3'd0;
         sr_q      <= 8'h00;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         sr_q      <= sr_d;
      end
   end

   // Next-state logic; a reload before the eighth bit aborts and restarts the frame
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sr_d      = sr_q;
      push_req  = 1'b0;
      abort_evt = 1'b0;
      push_byte = {sr_q[6:0], ser_in};
      case (state_q)
         S_IDLE: begin
            if (load_in) begin
               state_d   = S_SHIFT;
               bit_cnt_d = 3'd0;
            end
         end
         S_SHIFT: begin
            sr_d = push_byte;
            if (bit_cnt_q == 3'd7) begin
               push_req  = 1'b1;
               bit_cnt_d = 3'd0;
               state_d   = load_in ? S_SHIFT : S_IDLE;
            end else if (load_in) begin
               abort_evt = 1'b1;
               bit_cnt_d = 3'd0;
            end else begin
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state_q == S_SHIFT);
   end

   assign full       = (count_q == CW'(FIFO_DEPTH));
   assign rd_valid   = (count_q != '0);
   assign pop        = rd_valid & rd_ready;
   // A full FIFO still takes the byte when the head leaves at the same edge
   assign push_ok    = push_req & (~full | pop);
   assign rd_data    = rd_valid ? mem[rd_ptr_q] : 8'h00;
   assign fifo_count = count_q;

   always_ff @(posedge clk) begin
      if (rst_n && push_ok) begin
         mem[wr_ptr_q] <= push_byte;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Clear zeroes the status first; an event at the same edge lands on the zeroed value
   assign sum_base   = clear ? 8'h00 : sum_xor;
   assign abort_base = clear ? 4'h0 : abort_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_xor   <= 8'h00;
         abort_cnt <= 4'h0;
         overflow  <= 1'b0;
      end else begin
         sum_xor   <= sum_base ^ (push_ok ? push_byte : 8'h00);
         abort_cnt <= (abort_evt && abort_base != 4'hF) ? abort_base + 4'h1 : abort_base;
         overflow  <= (~clear & overflow) | (push_req & ~push_ok);
      end
   end

endmodule

// File: tb/tb_shift_rx_deframer.sv
// Directed bench for shift_rx_deframer: a model of the upstream shift register feeds ser_in,
// a vector table covers back-to-back fill/overflow, hand sequences cover aborts, clear and reset.
module tb_shift_rx_deframer;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          load_in  = 1'b0;
   logic          rd_ready = 1'b0;
   logic          clear    = 1'b0;
   logic          ser_in;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic [CW-1:0] fifo_count;
   logic          busy;
   logic          overflow;
   logic [3:0]    abort_cnt;
   logic [7:0]    sum_xor;

   logic [7:0]    tx_byte = 8'h00;
   logic [7:0]    tx_sr   = 8'h00;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0]    data;
      logic          rdy;
      logic [7:0]    exp_head;
      logic          exp_valid;
      logic [CW-1:0] exp_count;
      logic [7:0]    exp_sum;
      logic          exp_ov;
      logic          exp_busy;
   } vec_t;

   vec_t       tbl [6];
   logic [7:0] exp_q [$];

   shift_rx_deframer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_in    (load_in),
      .ser_in     (ser_in),
      .rd_ready   (rd_ready),
      .clear      (clear),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .fifo_count (fifo_count),
      .busy       (busy),
      .overflow   (overflow),
      .abort_cnt  (abort_cnt),
      .sum_xor    (sum_xor)
   );

   always #5 clk = ~clk;

   // Upstream load/shift-left register model
   always @(posedge clk) tx_sr <= load_in ? tx_byte : {tx_sr[6:0], 1'b0};
   assign ser_in = tx_sr[7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, rd_valid, 0);
      chk({tag, "_data"}, rd_data, 0);
      chk({tag, "_count"}, fifo_count, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ov"}, overflow, 0);
      chk({tag, "_abort"}, abort_cnt, 0);
      chk({tag, "_sum"}, sum_xor, 0);
   endtask

   task automatic chk_vec(input int i);
      chk($sformatf("vec%0d_valid", i), rd_valid, tbl[i].exp_valid);
      chk($sformatf("vec%0d_head", i), rd_data, tbl[i].exp_head);
      chk($sformatf("vec%0d_count", i), fifo_count, tbl[i].exp_count);
      chk($sformatf("vec%0d_sum", i), sum_xor, tbl[i].exp_sum);
      chk($sformatf("vec%0d_ov", i), overflow, tbl[i].exp_ov);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].exp_busy);
   endtask

   initial begin
      // data, rdy@T8, head, valid, count, sum, ov, busy -- all sampled just after that byte's T8
      tbl[0] = '{8'h11, 1'b0, 8'h11, 1'b1, 3'd1, 8'h11, 1'b0, 1'b1};
      tbl[1] = '{8'h22, 1'b0, 8'h11, 1'b1, 3'd2, 8'h33, 1'b0, 1'b1};
      tbl[2] = '{8'h33, 1'b0, 8'h11, 1'b1, 3'd3, 8'h00, 1'b0, 1'b1};
      tbl[3] = '{8'h44, 1'b0, 8'h11, 1'b1, 3'd4, 8'h44, 1'b0, 1'b1};
      tbl[4] = '{8'h55, 1'b0, 8'h11, 1'b1, 3'd4, 8'h44, 1'b1, 1'b1};
      tbl[5] = '{8'h66, 1'b1, 8'h22, 1'b1, 3'd4, 8'h22, 1'b1, 1'b0};

      // Reset and idle
      rst_n = 1'b0;
      repeat (2) step();
      chk_all_zero("reset");
      rst_n = 1'b1;
      repeat (20) step();
      chk_all_zero("idle");

      // Single byte, 8-cycle load-to-valid latency
      load_in = 1'b1; tx_byte = 8'hA5;
      step();
      load_in = 1'b0;
      chk("single_busy_t0", busy, 1);
      repeat (7) step();
      chk("single_valid_t7", rd_valid, 0);
      step();
      chk("single_valid", rd_valid, 1);
      chk("single_data", rd_data, 8'hA5);
      chk("single_count", fifo_count, 1);
      chk("single_sum", sum_xor, 8'hA5);
      chk("single_busy_t8", busy, 0);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      chk("single_pop_valid", rd_valid, 0);
      chk("single_pop_data", rd_data, 0);
      chk("single_pop_count", fifo_count, 0);

      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clear_sum", sum_xor, 0);

      // Back-to-back fill, overflow, and full with a same-edge pop
      for (int i = 0; i < 6; i++) begin
         load_in  = 1'b1;
         tx_byte  = tbl[i].data;
         rd_ready = (i > 0) ? tbl[i-1].rdy : 1'b0;
         step();
         rd_ready = 1'b0;
         load_in  = 1'b0;
         if (i > 0) chk_vec(i - 1);
         repeat (7) step();
      end
      rd_ready = tbl[5].rdy;
      step();
      rd_ready = 1'b0;
      chk_vec(5);

      exp_q = '{8'h22, 8'h33, 8'h44, 8'h66};
      while (exp_q.size() > 0) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         chk("drain_valid", rd_valid, 1);
         chk("drain_data", rd_data, e);
         rd_ready = 1'b1;
         step();
         rd_ready = 1'b0;
      end
      chk("drain_empty", rd_valid, 0);
      chk("drain_count", fifo_count, 0);

      // Abort: F0 loaded at T0, 0F reloaded at T3
      load_in = 1'b1; tx_byte = 8'hF0;
      step();
      load_in = 1'b0;
      repeat (2) step();
      load_in = 1'b1; tx_byte = 8'h0F;
      step();
      load_in = 1'b0;
      chk("abort_cnt1", abort_cnt, 1);
      chk("abort_busy", busy, 1);
      repeat (7) step();
      chk("abort_valid_early", rd_valid, 0);
      step();
      chk("abort_valid", rd_valid, 1);
      chk("abort_data", rd_data, 8'h0F);
      chk("abort_count", fifo_count, 1);
      chk("abort_sum", sum_xor, 8'h2D);
      chk("abort_ov_kept", overflow, 1);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;

      // Continuous reload: every edge after entry aborts; counter saturates
      load_in = 1'b1; tx_byte = 8'h5A;
      repeat (5) step();
      chk("abort_cnt5", abort_cnt, 5);
      repeat (16) step();
      load_in = 1'b0;
      chk("abort_sat", abort_cnt, 15);
      repeat (7) step();
      chk("sat_valid_early", rd_valid, 0);
      step();
      chk("sat_valid", rd_valid, 1);
      chk("sat_data", rd_data, 8'h5A);
      chk("sat_sum", sum_xor, 8'h77);
      chk("sat_abort_hold", abort_cnt, 15);

      // Clear at the T8 of 3C: checksum restarts from the new byte, FIFO kept
      load_in = 1'b1; tx_byte = 8'h3C;
      step();
      load_in = 1'b0;
      repeat (7) step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_sum", sum_xor, 8'h3C);
      chk("clr_ov", overflow, 0);
      chk("clr_abort", abort_cnt, 0);
      chk("clr_count", fifo_count, 2);
      chk("clr_head", rd_data, 8'h5A);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      chk("clr_next_head", rd_data, 8'h3C);

      // Reset at T4 of a frame
      load_in = 1'b1; tx_byte = 8'h77;
      step();
      load_in = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk_all_zero("rst_mid");
      repeat (12) step();
      chk_all_zero("rst_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
